// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared direction encoding, path mapping and width helpers for LED matrix blocks
package led_matrix_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  typedef enum logic {
    FWD = DIR_FWD,
    BWD = DIR_BWD
  } dir_state_e;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] c;
  } rc_t;

  // Serpentine mapping: even rows run left to right, odd rows right to left.
  function automatic rc_t path_to_rc(input int unsigned p, input int unsigned cols);
    rc_t         rc;
    int unsigned k;
    rc.r = p / cols;
    k    = p % cols;
    rc.c = rc.r[0] ? (cols - 1 - k) : k;
    return rc;
  endfunction

  function automatic int clog2(input int unsigned v);
    int w;
    w = 0;
    for (int unsigned x = 1; x < v; x = x << 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_row_scan.sv
// rtl/led_row_scan.sv - row-scan prescaler, row index and one-hot row select rotation
module led_row_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int SCAN_DIV = 13
) (
  input  logic                     clk_in,
  input  logic                     reset,
  output logic [clog2(ROWS)-1:0]   idx_o,
  output logic [ROWS-1:0]          row_o
);

  localparam int             IW       = clog2(ROWS);
  localparam logic [IW-1:0]  IDX_LAST = IW'(ROWS - 1);

  logic [SCAN_DIV-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ROWS-1:0]     row_q, row_d;
  logic                scan_tick;

  assign scan_tick  = &scan_cnt_q;
  assign scan_cnt_d = scan_cnt_q + 1'b1;
  assign idx_d      = scan_tick ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
  // Row 0 sits on the MSB, so advancing the scan rotates toward bit 0.
  assign row_d      = scan_tick ? {row_q[0], row_q[ROWS-1:1]} : row_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      row_q      <= {1'b1, {(ROWS-1){1'b0}}};
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
    end
  end

  assign idx_o = idx_q;
  assign row_o = row_q;

endmodule

// File: rtl/led_bounce_bar.sv
// rtl/led_bounce_bar.sv - bouncing light bar on a serpentine-scanned LED matrix
module led_bounce_bar
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int BAR_LEN      = 3,
  parameter int STEP_DIV     = 20,
  parameter int SCAN_DIV     = 13,
  parameter int COLOR_BY_DIR = 1
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            pause,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] column_green,
  output logic [COLS-1:0] column_red,
  output logic            dir
);

  localparam int            N     = ROWS * COLS;
  localparam int            T_END = N - BAR_LEN;
  localparam int            TW    = clog2(T_END + 1);
  localparam int            IW    = clog2(ROWS);
  localparam logic [TW-1:0] T_MAX = TW'(T_END);

  logic [STEP_DIV-1:0] step_cnt_q, step_cnt_d;
  logic                pause_meta_q, pause_s_q;
  logic [TW-1:0]       t_q;
  dir_state_e          state_q;
  logic [IW-1:0]       idx;
  logic                step_tick;
  logic [COLS-1:0]     lit;
  rc_t                 rc;

  assign step_cnt_d = step_cnt_q + 1'b1;
  assign step_tick  = &step_cnt_q;

  // The prescaler keeps running while paused; a paused tick is simply dropped.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      step_cnt_q   <= '0;
      pause_meta_q <= 1'b0;
      pause_s_q    <= 1'b0;
      t_q          <= '0;
      state_q      <= FWD;
    end else begin
      step_cnt_q   <= step_cnt_d;
      pause_meta_q <= pause;
      pause_s_q    <= pause_meta_q;
      if (step_tick && !pause_s_q) begin
        case (state_q)
          FWD: begin
            if (t_q == T_MAX) begin
              state_q <= BWD;
              t_q     <= t_q - 1'b1;
            end else begin
              t_q <= t_q + 1'b1;
            end
          end
          BWD: begin
            if (t_q == '0) begin
              state_q <= FWD;
              t_q     <= t_q + 1'b1;
            end else begin
              t_q <= t_q - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign dir = state_q;

  led_row_scan #(
    .ROWS    (ROWS),
    .SCAN_DIV(SCAN_DIV)
  ) u_row_scan (
    .clk_in(clk_in),
    .reset (reset),
    .idx_o (idx),
    .row_o (row)
  );

  // Walk the bar's pixels and light those that land in the active row.
  always_comb begin
    lit = '0;
    rc  = '0;
    for (int j = 0; j < BAR_LEN; j++) begin
      rc = path_to_rc(32'(t_q) + 32'(j), COLS);
      for (int c = 0; c < COLS; c++) begin
        if (rc.r == 32'(idx) && rc.c == 32'(c)) lit[COLS-1-c] = 1'b1;
      end
    end
  end

  assign column_green = (COLOR_BY_DIR == 0 || state_q == FWD) ? lit : '0;
  assign column_red   = (COLOR_BY_DIR != 0 && state_q == BWD) ? lit : '0;

endmodule

// File: tb/tb_led_bounce_bar.sv
// tb/tb_led_bounce_bar.sv - randomized self-checking bench for led_bounce_bar
module tb_led_bounce_bar;

  localparam int NPIX   = 64;
  localparam int BL     = 3;
  localparam int TMAX   = NPIX - BL;
  localparam int PERIOD = 2 * TMAX;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       pause;
  logic [7:0] row, column_green, column_red;
  logic       dir;

  int  n_chk = 0;
  int  n_err = 0;
  bit  chk_en = 0;

  int  m_cyc, m_k;
  bit  m_pm, m_ps;

  led_bounce_bar #(
    .ROWS(8), .COLS(8), .BAR_LEN(BL), .STEP_DIV(2), .SCAN_DIV(1), .COLOR_BY_DIR(1)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .pause       (pause),
    .row         (row),
    .column_green(column_green),
    .column_red  (column_red),
    .dir         (dir)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // m_k counts the steps actually taken; the bar position is a closed-form fold of it.
  function automatic void bar_pos(input int k, output int t, output bit d);
    int m;
    if (k == 0) begin
      t = 0; d = 0;
    end else begin
      m = (k - 1) % PERIOD + 1;
      if (m <= TMAX) begin t = m;          d = 0; end
      else           begin t = PERIOD - m; d = 1; end
    end
  endfunction

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_k = 0; m_pm = 0; m_ps = 0;
    end else begin
      if ((m_cyc % 4) == 3 && !m_ps) m_k++;
      m_ps = m_pm;
      m_pm = pause;
      m_cyc++;
    end
  end

  always @(negedge clk_in) begin
    int t, idx, p;
    bit d;
    logic [7:0] lit, er;
    if (!reset && chk_en) begin
      bar_pos(m_k, t, d);
      idx = (m_cyc / 2) % 8;
      lit = '0;
      for (int c = 0; c < 8; c++) begin
        p = idx * 8 + ((idx % 2 == 0) ? c : 7 - c);
        if (p >= t && p < t + BL) lit[7-c] = 1'b1;
      end
      er = 8'h80;
      er = er >> idx;
      check("row", row, er);
      check("dir", dir, d);
      check("green", column_green, d ? 0 : lit);
      check("red", column_red, d ? lit : 0);
    end
  end

  task automatic wait_k(input int target);
    int budget;
    budget = (target - m_k) * 4 + 64;
    while (m_k < target && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    check("step_count_reached", m_k, target);
  endtask

  task automatic wait_row(input logic [7:0] target);
    int budget;
    budget = 40;
    while (row !== target && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    check("row_reached", row, target);
  endtask

  initial begin
    int cnt;
    int mt;
    bit md;
    reset = 1'b1;
    pause = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    #1;
    check("rst_row", row, 8'h80);
    check("rst_green", column_green, 8'he0);
    check("rst_red", column_red, 8'h00);
    check("rst_dir", dir, 0);
    check("rst_t", dut.t_q, 0);
    chk_en = 1;

    bar_pos(62, mt, md);
    check("model_t_62", mt, 60);
    check("model_d_62", md, 1);
    bar_pos(123, mt, md);
    check("model_t_123", mt, 1);

    wait_k(1);
    check("first_tick_t", dut.t_q, 1);

    wait_k(6);
    pause = 1'b1;
    wait_row(8'h80);
    check("wrap_row0", column_green, 8'h03);
    wait_row(8'h40);
    check("wrap_row1", column_green, 8'h01);
    repeat (40) @(negedge clk_in);
    check("pause_t", dut.t_q, 6);
    check("pause_dir", dir, 0);
    pause = 1'b0;
    cnt = 0;
    while (dut.t_q == 6 && cnt < 12) begin
      @(negedge clk_in);
      cnt++;
    end
    check("resume_t", dut.t_q, 7);
    check("resume_latency", int'(cnt <= 6), 1);
    repeat (4) @(negedge clk_in);
    check("no_catch_up", dut.t_q, 8);

    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    wait_k(61);
    check("end_t", dut.t_q, 61);
    check("end_dir", dir, 0);
    wait_k(62);
    check("bounce_t", dut.t_q, 60);
    check("bounce_dir", dir, 1);
    check("bounce_green_off", column_green, 0);
    wait_k(92);
    check("bwd30_t", dut.t_q, 30);
    wait_k(122);
    check("start_t", dut.t_q, 0);
    check("start_dir", dir, 1);
    wait_k(123);
    check("rebounce_t", dut.t_q, 1);
    check("rebounce_dir", dir, 0);
    wait_k(214);
    check("mid_t", dut.t_q, 30);
    check("mid_dir", dir, 1);

    pause = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_t", dut.t_q, 0);
    check("async_rst_dir", dir, 0);
    check("async_rst_row", row, 8'h80);
    repeat (3) @(negedge clk_in);
    pause = 1'b0;
    reset = 1'b0;

    repeat (800) begin
      @(negedge clk_in);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
    end
    pause = 1'b0;
    repeat (4) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_bounce_bar.md
Name: led_bounce_bar

Overview:
- Parametrised successor to the team's fixed 8×8 3-bit flowing-light display.
- Drives a ROWS×COLS LED matrix with a BAR_LEN-pixel light bar along a serpentine path: row 0 left→right, row 1 right→left, and so on.
- The bar bounces at both path ends, can be paused, and is coloured by direction.
- Sits between the board clock and the matrix pins; it contains its own step prescaler and row-scan multiplexer.

Parameters:
- ROWS, 8, number of matrix rows (≥2).
- COLS, 8, number of matrix columns (≥2).
- BAR_LEN, 3, lit pixels in the bar (1 ≤ BAR_LEN < ROWS*COLS).
- STEP_DIV, 20, bar moves once every 2^STEP_DIV clk_in cycles.
- SCAN_DIV, 13, row scan advances once every 2^SCAN_DIV clk_in cycles.
- COLOR_BY_DIR, 1, 1: green on forward moves, red on backward moves; 0: always green.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pause  in  1  asynchronous switch; 1 freezes the bar.
- row  out  ROWS  one-hot active-high row select; bit ROWS-1 = row 0.
- column_green  out  COLS  green column data for the selected row; bit COLS-1 = column 0 (leftmost).
- column_red  out  COLS  red column data for the selected row, same bit order.
- dir  out  1  0 = forward (toward the path end), 1 = backward.

Behaviour:
- Path index p ∈ [0, N-1], with N = ROWS*COLS.
  - row r = p / COLS; k = p mod COLS.
  - column c = k if r is even, else COLS-1-k.
- State: tail t ∈ [0, N-BAR_LEN]; the bar lights p = t .. t+BAR_LEN-1. Direction FSM has states FWD (dir=0) and BWD (dir=1).
- Reset (async): t=0, FWD, prescalers=0, scan idx=0, row = one-hot bit ROWS-1, pause synchroniser=0.
- pause goes through a 2-flop synchroniser (pause_s). There are 2 clk_in cycles of latency from a pause edge to its effect.
- Step tick:
  - Free-running STEP_DIV-bit counter; the tick is a 1-cycle pulse when the counter is all ones.
  - The counter runs during pause.
  - A tick with pause_s=1 is ignored and is not deferred.
- On a tick with pause_s=0:
  - FWD, t < N-BAR_LEN: t+1.
  - FWD, t = N-BAR_LEN: go to BWD and t-1 on the same tick. The end position is shown for exactly one step period.
  - BWD, t > 0: t-1.
  - BWD, t = 0: go to FWD and t+1 on the same tick.
- Scan:
  - Separate SCAN_DIV-bit prescaler; on its all-ones cycle, idx ← (idx+1) mod ROWS and row rotates one position toward bit 0.
  - Wrap: idx ROWS-1→0; row bit 0 → bit ROWS-1.
- Columns are combinational from the registered idx, t and dir.
  - Column c of the active row is lit iff its path index lies in [t, t+BAR_LEN-1].
  - COLOR_BY_DIR=1: lit pixels appear on column_green when dir=0, on column_red when dir=1; the other bus is 0.
  - COLOR_BY_DIR=0: lit pixels always appear on column_green; column_red is always 0.
- The bar spans row boundaries correctly, following the serpentine turn.
- Reset mid-operation returns to the reset state immediately, regardless of pause.
- Width of t, idx and prescalers is $clog2 of the respective range. No arithmetic overflow is permitted: t stays in [0, N-BAR_LEN] by construction.

Decomposition:
- Package led_matrix_pkg holds:
  - the dir encoding constants DIR_FWD=0 and DIR_BWD=1;
  - a function path_to_rc(p, COLS) returning row/column;
  - a function clog2 helper.
- One sub-module, led_row_scan: scan prescaler, idx counter and one-hot row rotation, parametrised by ROWS and SCAN_DIV. It is reusable by the other matrix blocks.

Test Plan (STEP_DIV=2, SCAN_DIV=1, defaults otherwise):
- Reset released, pause=0 → t=0, dir=0, row=8'b1000_0000, column_green=8'b1110_0000 while idx=0; t=1 after the first tick.
- Run 61 ticks from reset → t=61 (end) shown one step with dir=0. The next tick gives dir=1, t=60, colour switches to column_red, column_green=0.
- t=6 → row 0 shows 8'b0000_0011 and row 1 shows 8'b0000_0001 (serpentine wrap across rows 0/1).
- BWD reaching t=0 → the next tick gives dir=0, t=1; a full bounce cycle is 122 ticks.
- pause=1 held for 10 ticks → t and dir unchanged. Deassert → motion resumes within 2 cycles plus the next tick; no catch-up steps.
- Assert reset with t=30, dir=1 → within the same cycle t=0, dir=0, row=8'b1000_0000.
